// File: rtl/fifo_pkg.sv
// Shared constants, depth helper and status bundle for the FIFO controller.
// Imported by fifo_ctrl_if, fifo_ptr and fifo_ctrl.
package fifo_pkg;

    localparam int FIFO_ADDR_BITS   = 3;
    localparam int FIFO_WORD_LENGTH = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO user (master) and fifo_ctrl (slave).
// Ports: wr_i/rd_i/clr_i requests; wr_en_o, w/r addresses, count, status, error flags.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int AddrBits = FIFO_ADDR_BITS
) ();

    logic                wr_i;
    logic                rd_i;
    logic                clr_i;
    logic                wr_en_o;
    logic [AddrBits-1:0] w_addr_o;
    logic [AddrBits-1:0] r_addr_o;
    logic [AddrBits:0]   count_o;
    logic                full_o;
    logic                empty_o;
    logic                almost_full_o;
    logic                almost_empty_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output wr_i, rd_i, clr_i,
        input  wr_en_o, w_addr_o, r_addr_o, count_o,
        input  full_o, empty_o, almost_full_o, almost_empty_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  wr_i, rd_i, clr_i,
        output wr_en_o, w_addr_o, r_addr_o, count_o,
        output full_o, empty_o, almost_full_o, almost_empty_o,
        output overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping Bits-wide pointer register: async reset, sync clear, increment enable.
// Ports: clk_i, rst_i, clr_i (priority over inc_i), inc_i, ptr_o.
module fifo_ptr #(
    parameter int Bits = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [Bits-1:0] ptr_o
);

    logic [Bits-1:0] r_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= r_ptr + Bits'(1);
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller driving a register file with async read.
// Ports: clk_i, rst_i (async, active-high), bus (fifo_ctrl_if.slave).
// Optional sticky overflow/underflow flags: define FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AddrBits      = FIFO_ADDR_BITS,
    parameter int AlmostFullTh  = 6,
    parameter int AlmostEmptyTh = 2
) (
    input logic        clk_i,
    input logic        rst_i,
    fifo_ctrl_if.slave bus
);

    localparam logic [AddrBits:0] Depth =
        (AddrBits+1)'(fifo_depth(int'(AddrBits)));
    localparam logic [AddrBits:0] AfTh = (AddrBits+1)'(AlmostFullTh);
    localparam logic [AddrBits:0] AeTh = (AddrBits+1)'(AlmostEmptyTh);

    logic [AddrBits:0]   r_count;
    logic [AddrBits:0]   w_count_nxt;
    logic [AddrBits-1:0] w_head;
    logic [AddrBits-1:0] w_tail;
    logic                w_wr_acc;
    logic                w_rd_acc;
    fifo_status_t        w_status;

    // Status depends on the count register only.
    assign w_status.full         = (r_count == Depth);
    assign w_status.empty        = (r_count == '0);
    assign w_status.almost_full  = (r_count >= AfTh);
    assign w_status.almost_empty = (r_count <= AeTh);

    // A flush suppresses both accepts so nothing reaches the register file.
    assign w_wr_acc = bus.wr_i & ~w_status.full & ~bus.clr_i;
    assign w_rd_acc = bus.rd_i & ~w_status.empty & ~bus.clr_i;

    fifo_ptr #(.Bits(AddrBits)) u_tail (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (w_wr_acc),
        .ptr_o (w_tail)
    );

    fifo_ptr #(.Bits(AddrBits)) u_head (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr_i),
        .inc_i (w_rd_acc),
        .ptr_o (w_head)
    );

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + (AddrBits+1)'(1);
            2'b01:   w_count_nxt = r_count - (AddrBits+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (bus.clr_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_i & w_status.full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_i & w_status.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
`else
    assign bus.overflow_o  = 1'b0;
    assign bus.underflow_o = 1'b0;
`endif

    assign bus.wr_en_o        = w_wr_acc;
    assign bus.w_addr_o       = w_tail;
    assign bus.r_addr_o       = w_head;
    assign bus.count_o        = r_count;
    assign bus.full_o         = w_status.full;
    assign bus.empty_o        = w_status.empty;
    assign bus.almost_full_o  = w_status.almost_full;
    assign bus.almost_empty_o = w_status.almost_empty;

endmodule
